change_dispenser: RTL and testbench

//  Downstream of the vending controller: takes a change amount (the vending MO value) and pays it
//  out one coin per handshake from a finite coin inventory using greedy largest-first selection.

---
 rtl/change_dispenser_pkg.sv | 30 +++
 rtl/change_dispenser_coin_picker.sv | 46 ++++
 rtl/change_dispenser.sv | 186 ++++++++++++++++++
 tb/tb_change_dispenser.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/change_dispenser_pkg.sv
// Shared definitions for the vending datapath: dispenser FSM encoding,
// coin-type indices, default denominations and the vending controller's
// product prices.
package change_dispenser_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SELECT = 2'd1,
    ST_ISSUE  = 2'd2,
    ST_DONE   = 2'd3
  } disp_state_t;

  // Coin-type indices, largest denomination first.
  localparam logic [1:0] COIN_0 = 2'd0;
  localparam logic [1:0] COIN_1 = 2'd1;
  localparam logic [1:0] COIN_2 = 2'd2;
  localparam logic [1:0] COIN_3 = 2'd3;

  // Default denominations, strictly descending.
  localparam int DEN0_DEF = 50;
  localparam int DEN1_DEF = 10;
  localparam int DEN2_DEF = 5;
  localparam int DEN3_DEF = 1;

  // Vending controller product prices (same currency unit as the coins).
  localparam int PROD_A_PRICE = 35;
  localparam int PROD_B_PRICE = 60;
  localparam int PROD_C_PRICE = 85;

endpackage

// File: rtl/change_dispenser_coin_picker.sv
// coin_picker: greedy largest-first selection. Returns the lowest coin index
// whose value fits in the remainder and whose inventory is non-zero.
module coin_picker
  import change_dispenser_pkg::*;
#(
  parameter int AMT_W = 8,
  parameter int CNT_W = 4,
  parameter int DEN0  = DEN0_DEF,
  parameter int DEN1  = DEN1_DEF,
  parameter int DEN2  = DEN2_DEF,
  parameter int DEN3  = DEN3_DEF
) (
  input  logic [AMT_W-1:0]      rem,
  input  logic [3:0][CNT_W-1:0] cnt,
  output logic                  found,
  output logic [1:0]            sel
);

  localparam logic [AMT_W-1:0] D0 = AMT_W'(DEN0);
  localparam logic [AMT_W-1:0] D1 = AMT_W'(DEN1);
  localparam logic [AMT_W-1:0] D2 = AMT_W'(DEN2);
  localparam logic [AMT_W-1:0] D3 = AMT_W'(DEN3);

  // Priority pick, largest denomination wins.
  always_comb begin
    found = 1'b0;
    sel   = COIN_0;
    if ((D0 <= rem) && (cnt[0] != {CNT_W{1'b0}})) begin
      found = 1'b1;
      sel   = COIN_0;
    end else if ((D1 <= rem) && (cnt[1] != {CNT_W{1'b0}})) begin
      found = 1'b1;
      sel   = COIN_1;
    end else if ((D2 <= rem) && (cnt[2] != {CNT_W{1'b0}})) begin
      found = 1'b1;
      sel   = COIN_2;
    end else if ((D3 <= rem) && (cnt[3] != {CNT_W{1'b0}})) begin
      found = 1'b1;
      sel   = COIN_3;
    end else begin
      found = 1'b0;
      sel   = COIN_0;
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// change_dispenser: pays a change amount out one coin per handshake from a
// four-denomination inventory, greedy largest-first, reporting any unpaid
// remainder. Optional feature: define CHANGE_TOTAL_EN to add total_out, the
// running 16-bit value of all coins handed out since reset.
module change_dispenser
  import change_dispenser_pkg::*;
#(
  parameter int AMT_W = 8,
  parameter int CNT_W = 4,
  parameter int DEN0  = DEN0_DEF,
  parameter int DEN1  = DEN1_DEF,
  parameter int DEN2  = DEN2_DEF,
  parameter int DEN3  = DEN3_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             amt_valid,
  input  logic [AMT_W-1:0] amt,
  output logic             in_ready,
  input  logic             inv_load,
  input  logic [1:0]       inv_sel,
  input  logic [CNT_W-1:0] inv_cnt,
  output logic             coin_valid,
  output logic [1:0]       coin_type,
  input  logic             coin_ready,
  output logic             done,
  output logic             short,
  output logic [AMT_W-1:0] remain,
  output logic             empty
`ifdef CHANGE_TOTAL_EN
  ,
  output logic [15:0]      total_out
`endif
);

  disp_state_t           state_r, state_nxt_s;
  logic [AMT_W-1:0]      rem_r;
  logic [3:0][CNT_W-1:0] inv_r;
  logic                  coin_valid_r;
  logic [1:0]            coin_type_r;
  logic                  done_r;
  logic                  short_r;
  logic [AMT_W-1:0]      remain_r;

  logic                  found_s;
  logic [1:0]            pick_sel_s;
  logic                  accept_s;
  logic                  handshake_s;
  logic [AMT_W-1:0]      rem_after_s;
  logic                  short_nxt_s;
  logic [AMT_W-1:0]      remain_nxt_s;

  function automatic logic [AMT_W-1:0] coin_value(input logic [1:0] idx);
    case (idx)
      COIN_0:  coin_value = AMT_W'(DEN0);
      COIN_1:  coin_value = AMT_W'(DEN1);
      COIN_2:  coin_value = AMT_W'(DEN2);
      COIN_3:  coin_value = AMT_W'(DEN3);
      default: coin_value = {AMT_W{1'b0}};
    endcase
  endfunction

  coin_picker #(
    .AMT_W(AMT_W), .CNT_W(CNT_W),
    .DEN0(DEN0), .DEN1(DEN1), .DEN2(DEN2), .DEN3(DEN3)
  ) u_picker (
    .rem   (rem_r),
    .cnt   (inv_r),
    .found (found_s),
    .sel   (pick_sel_s)
  );

  assign in_ready    = (state_r == ST_IDLE) && !inv_load;
  assign accept_s    = amt_valid && in_ready;
  assign handshake_s = (state_r == ST_ISSUE) && coin_ready;
  // Only consumed on a handshake, where the picker already proved no underflow.
  assign rem_after_s = rem_r - coin_value(coin_type_r);
  assign empty       = (inv_r == {(4*CNT_W){1'b0}});

  assign coin_valid  = coin_valid_r;
  assign coin_type   = coin_type_r;
  assign done        = done_r;
  assign short       = short_r;
  assign remain      = remain_r;

  // Next-state decode plus the completion status to publish with done.
  always_comb begin
    state_nxt_s  = state_r;
    short_nxt_s  = 1'b0;
    remain_nxt_s = {AMT_W{1'b0}};
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (amt == {AMT_W{1'b0}}) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_SELECT;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SELECT: begin
        if (found_s) begin
          state_nxt_s = ST_ISSUE;
        end else begin
          state_nxt_s  = ST_DONE;
          short_nxt_s  = 1'b1;
          remain_nxt_s = rem_r;
        end
      end
      ST_ISSUE: begin
        if (coin_ready) begin
          if (rem_after_s == {AMT_W{1'b0}}) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_SELECT;
          end
        end else begin
          state_nxt_s = ST_ISSUE;
        end
      end
      ST_DONE:  state_nxt_s = ST_IDLE;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // State register and registered handshake/status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      coin_valid_r <= 1'b0;
      coin_type_r  <= COIN_0;
      done_r       <= 1'b0;
      short_r      <= 1'b0;
      remain_r     <= {AMT_W{1'b0}};
    end else begin
      state_r      <= state_nxt_s;
      coin_valid_r <= (state_nxt_s == ST_ISSUE);
      if ((state_r == ST_SELECT) && found_s) begin
        coin_type_r <= pick_sel_s;
      end
      done_r       <= (state_nxt_s == ST_DONE);
      short_r      <= short_nxt_s;
      remain_r     <= remain_nxt_s;
    end
  end

  // Outstanding change: loaded on accept, reduced by each coin handed out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_r <= {AMT_W{1'b0}};
    end else if (accept_s) begin
      rem_r <= amt;
    end else if (handshake_s) begin
      rem_r <= rem_after_s;
    end
  end

  // Coin inventory: host writes while idle, payout decrements on handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inv_r <= {(4*CNT_W){1'b0}};
    end else if ((state_r == ST_IDLE) && inv_load) begin
      inv_r[inv_sel] <= inv_cnt;
    end else if (handshake_s && (inv_r[coin_type_r] != {CNT_W{1'b0}})) begin
      inv_r[coin_type_r] <= inv_r[coin_type_r] - {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

`ifdef CHANGE_TOTAL_EN
  logic [15:0] total_r;

  // Running value of every coin handed out, wrapping at 16 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      total_r <= 16'd0;
    end else if (handshake_s) begin
      total_r <= total_r + 16'(coin_value(coin_type_r));
    end
  end

  assign total_out = total_r;
`endif

endmodule

// File: tb/tb_change_dispenser.sv
// Directed self-checking bench for change_dispenser.
module tb_change_dispenser;
  import change_dispenser_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       amt_valid;
  logic [7:0] amt;
  logic       in_ready;
  logic       inv_load;
  logic [1:0] inv_sel;
  logic [3:0] inv_cnt;
  logic       coin_valid;
  logic [1:0] coin_type;
  logic       coin_ready;
  logic       done;
  logic       short;
  logic [7:0] remain;
  logic       empty;
`ifdef CHANGE_TOTAL_EN
  logic [15:0] total_out;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int coins_q[$];
  int done_cyc;
  int first_cyc;

  change_dispenser dut (
    .clk        (clk),
    .rst        (rst),
    .amt_valid  (amt_valid),
    .amt        (amt),
    .in_ready   (in_ready),
    .inv_load   (inv_load),
    .inv_sel    (inv_sel),
    .inv_cnt    (inv_cnt),
    .coin_valid (coin_valid),
    .coin_type  (coin_type),
    .coin_ready (coin_ready),
    .done       (done),
    .short      (short),
    .remain     (remain),
    .empty      (empty)
`ifdef CHANGE_TOTAL_EN
    ,
    .total_out  (total_out)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [1:0] sel, input logic [3:0] cnt);
    inv_load = 1'b1;
    inv_sel  = sel;
    inv_cnt  = cnt;
    tick();
    inv_load = 1'b0;
  endtask

  task automatic request(input string tag, input logic [7:0] a);
    amt_valid = 1'b1;
    amt       = a;
    #1;
    check_eq({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    tick();
    amt_valid = 1'b0;
  endtask

  // Observe cycles after an accept until done, recording every offered coin.
  task automatic run_payout(input string tag, input int budget);
    bit fin;
    coins_q.delete();
    done_cyc  = -1;
    first_cyc = -1;
    fin       = 1'b0;
    for (int c = 0; c < budget && !fin; c++) begin
      if (coin_valid) begin
        if (first_cyc < 0) first_cyc = c;
        coins_q.push_back(int'(coin_type));
      end
      if (done) begin
        done_cyc = c;
        fin      = 1'b1;
      end else begin
        tick();
      end
    end
    if (!fin) check_eq({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic check_coins(input string tag, input logic [15:0] exp, input int n);
    check_eq({tag, "_ncoins"}, 32'(coins_q.size()), 32'(n));
    for (int i = 0; i < n && i < coins_q.size(); i++) begin
      check_eq($sformatf("%s_coin%0d", tag, i), 32'(coins_q[i]), 32'(exp[2*i +: 2]));
    end
  endtask

  task automatic check_inv(input string tag, input int i0, input int i1, input int i2, input int i3);
    check_eq({tag, "_inv0"}, 32'(dut.inv_r[0]), 32'(i0));
    check_eq({tag, "_inv1"}, 32'(dut.inv_r[1]), 32'(i1));
    check_eq({tag, "_inv2"}, 32'(dut.inv_r[2]), 32'(i2));
    check_eq({tag, "_inv3"}, 32'(dut.inv_r[3]), 32'(i3));
  endtask

  initial begin
    rst = 1'b1; amt_valid = 1'b0; amt = 8'd0; inv_load = 1'b0;
    inv_sel = 2'd0; inv_cnt = 4'd0; coin_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #1;
    // Reset state
    check_eq("rst_coin_valid", 32'(coin_valid), 32'd0);
    check_eq("rst_coin_type", 32'(coin_type), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_short", 32'(short), 32'd0);
    check_eq("rst_remain", 32'(remain), 32'd0);
    check_eq("rst_empty", 32'(empty), 32'd1);
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);

    // Full payout of 67 from {2,3,1,4}: 50,10,5,1,1
    load(2'd0, 4'd2); load(2'd1, 4'd3); load(2'd2, 4'd1); load(2'd3, 4'd4);
    check_inv("t1_loaded", 2, 3, 1, 4);
    request("t1", 8'd67);
    check_eq("t1_select_no_coin", 32'(coin_valid), 32'd0);
    run_payout("t1", 60);
    check_coins("t1", 16'h03E4, 5);
    check_eq("t1_first_coin_cyc", 32'(first_cyc), 32'd1);
    check_eq("t1_done_cyc", 32'(done_cyc), 32'd10);
    check_eq("t1_short", 32'(short), 32'd0);
    check_eq("t1_remain", 32'(remain), 32'd0);
    check_inv("t1", 1, 2, 0, 2);
    tick();
    check_eq("t1_done_one_cycle", 32'(done), 32'd0);
    check_eq("t1_back_idle", 32'(in_ready), 32'd1);

    // Shortfall: only two 1-coins for 7
    load(2'd0, 4'd0); load(2'd1, 4'd0); load(2'd2, 4'd0); load(2'd3, 4'd2);
    request("t2", 8'd7);
    run_payout("t2", 60);
    check_coins("t2", 16'h000F, 2);
    check_eq("t2_done_cyc", 32'(done_cyc), 32'd5);
    check_eq("t2_short", 32'(short), 32'd1);
    check_eq("t2_remain", 32'(remain), 32'd5);
    check_eq("t2_empty", 32'(empty), 32'd1);
    check_inv("t2", 0, 0, 0, 0);
    tick();
    check_eq("t2_short_cleared", 32'(short), 32'd0);

    // Zero amount: straight to done, no coins
    request("t3", 8'd0);
    run_payout("t3", 10);
    check_eq("t3_ncoins", 32'(coins_q.size()), 32'd0);
    check_eq("t3_done_cyc", 32'(done_cyc), 32'd0);
    check_eq("t3_short", 32'(short), 32'd0);
    check_eq("t3_remain", 32'(remain), 32'd0);
    tick();

    // Back-pressure: coin_ready low for 5 cycles in ISSUE
    load(2'd3, 4'd3);
    coin_ready = 1'b0;
    request("t4", 8'd2);
    tick();
    for (int i = 0; i < 5; i++) begin
      check_eq($sformatf("t4_hold_valid%0d", i), 32'(coin_valid), 32'd1);
      check_eq($sformatf("t4_hold_type%0d", i), 32'(coin_type), 32'd3);
      check_eq($sformatf("t4_hold_inv%0d", i), 32'(dut.inv_r[3]), 32'd3);
      tick();
    end
    coin_ready = 1'b1;
    tick();
    check_eq("t4_after_hs_inv", 32'(dut.inv_r[3]), 32'd2);
    check_eq("t4_after_hs_valid", 32'(coin_valid), 32'd0);
    tick();
    check_eq("t4_second_valid", 32'(coin_valid), 32'd1);
    tick();
    check_eq("t4_done", 32'(done), 32'd1);
    check_eq("t4_short", 32'(short), 32'd0);
    check_eq("t4_inv_end", 32'(dut.inv_r[3]), 32'd1);
    tick();

    // inv_load wins over amt_valid in the same idle cycle
    inv_load = 1'b1; inv_sel = 2'd2; inv_cnt = 4'd1;
    amt_valid = 1'b1; amt = 8'd5;
    #1;
    check_eq("t5_in_ready_blocked", 32'(in_ready), 32'd0);
    tick();
    inv_load = 1'b0;
    check_eq("t5_still_idle", 32'(dut.state_r), 32'(ST_IDLE));
    check_eq("t5_inv2_loaded", 32'(dut.inv_r[2]), 32'd1);
    request("t5", 8'd5);
    run_payout("t5", 20);
    check_coins("t5", 16'h0002, 1);
    check_eq("t5_short", 32'(short), 32'd0);
    check_eq("t5_inv2_end", 32'(dut.inv_r[2]), 32'd0);
    tick();

    // Reset in the middle of a three-coin payout
    load(2'd3, 4'd3);
    request("t6", 8'd3);
    tick(); tick();
    check_eq("t6_one_paid", 32'(dut.inv_r[3]), 32'd2);
    rst = 1'b1;
    #1;
    check_eq("t6_state", 32'(dut.state_r), 32'(ST_IDLE));
    check_eq("t6_coin_valid", 32'(coin_valid), 32'd0);
    check_eq("t6_done", 32'(done), 32'd0);
    check_eq("t6_empty", 32'(empty), 32'd1);
    check_inv("t6", 0, 0, 0, 0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check_eq($sformatf("t6_no_done%0d", i), 32'(done | coin_valid), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
